// File: rtl/xilinx_bram_port_arbiter.sv
// Round-robin arbiter sharing one port of a xilinx_tdp_bram between NUM_REQ requesters,
// with an optional post-reset zero-fill of the whole RAM and one-hot tagged read returns.
module xilinx_bram_port_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned WE_WIDTH       = 2,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*WE_WIDTH-1:0]      req_be,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             init_done,
  output logic                             bram_en,
  output logic [WE_WIDTH-1:0]              bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_di,
  output logic                             bram_regce,
  input  logic [DATA_WIDTH-1:0]            bram_do
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {ST_CLEAR, ST_ARB} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_d;
  logic [PTR_W-1:0]        ptr, ptr_d, gnt_idx;
  logic                    found, hs;
  logic [NUM_REQ-1:0]      grant, tag_d;

  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [WE_WIDTH-1:0]     sel_be;

  logic                    en_d;
  logic [WE_WIDTH-1:0]     we_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   di_d;

  logic [NUM_REQ-1:0]      tag_q [READ_LATENCY+1];

  // First valid requester at or above the pointer, wrapping; gated until traffic is allowed
  always_comb begin : arb_c
    int unsigned idx;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[PTR_W'(idx)]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    hs = found && init_done;
    if (hs) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;

  assign sel_write = req_write[gnt_idx];
  assign sel_addr  = req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be    = req_be[32'(gnt_idx)*WE_WIDTH +: WE_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_d;
  end

  // Next state plus the values the registered command stage takes next cycle
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ptr_d   = ptr;
    en_d    = 1'b0;
    we_d    = '0;
    addr_d  = '0;
    di_d    = '0;
    tag_d   = '0;
    case (state)
      ST_CLEAR: begin
        en_d   = 1'b1;
        we_d   = '1;
        addr_d = cnt;
        cnt_d  = cnt + ADDR_WIDTH'(1);
        if (cnt == '1) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (hs) begin
          en_d   = 1'b1;
          addr_d = sel_addr;
          di_d   = sel_wdata;
          if (sel_write) we_d  = sel_be;
          else           tag_d = grant;
          if (gnt_idx == PTR_W'(NUM_REQ - 1)) ptr_d = '0;
          else                                ptr_d = gnt_idx + PTR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      ptr        <= '0;
      init_done  <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= '0;
      bram_addr  <= '0;
      bram_di    <= '0;
      bram_regce <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      ptr        <= ptr_d;
      init_done  <= (state == ST_ARB);
      bram_en    <= en_d;
      bram_we    <= we_d;
      bram_addr  <= addr_d;
      bram_di    <= di_d;
      bram_regce <= (state == ST_ARB) && (READ_LATENCY == 2);
    end
  end

  // Read tags ride alongside the BRAM pipeline; reset drops any in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= READ_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int unsigned k = 1; k <= READ_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign rsp_valid = tag_q[READ_LATENCY];
  assign rsp_rdata = bram_do;

endmodule

// File: tb/tb_xilinx_bram_port_arbiter.sv
// Bench for xilinx_bram_port_arbiter: BRAM model, directed scenarios and randomized traffic
// checked every cycle against a queue/array based reference model.
module tb_xilinx_bram_port_arbiter;
  localparam int N   = 4;
  localparam int AW  = 4;
  localparam int DW  = 18;
  localparam int WEW = 2;
  localparam int LW  = DW / WEW;
  localparam int RL  = 1;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*WEW-1:0]  req_be;
  logic [DW-1:0]     rsp_rdata, bram_di, bram_do;
  logic              init_done, bram_en, bram_regce;
  logic [WEW-1:0]    bram_we;
  logic [AW-1:0]     bram_addr;

  always #5 clk = ~clk;

  xilinx_bram_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WEW),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di),
    .bram_regce(bram_regce), .bram_do(bram_do)
  );

  // Single-port BRAM with byte lanes and optional output register
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] do_a, do_b;
  always @(posedge clk) begin
    if (bram_en) begin
      for (int k = 0; k < WEW; k++)
        if (bram_we[k]) mem[bram_addr][k*LW +: LW] <= bram_di[k*LW +: LW];
      do_a <= mem[bram_addr];
    end
  end
  always @(posedge clk) if (bram_regce) do_b <= do_a;
  assign bram_do = (RL == 2) ? do_b : do_a;

  // Per-requester stimulus
  logic           v [N];
  logic           w [N];
  logic [AW-1:0]  a [N];
  logic [DW-1:0]  d [N];
  logic [WEW-1:0] b [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = v[i];
      req_write[i]             = w[i];
      req_addr[i*AW +: AW]     = a[i];
      req_wdata[i*DW +: DW]    = d[i];
      req_be[i*WEW +: WEW]     = b[i];
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Reference model: RAM contents as an array, outstanding reads as a due-dated queue
  typedef struct { int due; logic [N-1:0] tag; logic [DW-1:0] data; } exp_t;
  exp_t q[$];
  logic [DW-1:0] shadow [DEPTH];
  bit chk_on = 0;
  int epoch = 0, seen_epoch = 0;
  int ptr, cyc, gi;
  logic [N-1:0]   exp_r;
  logic           prev_en;
  logic [WEW-1:0] prev_we;
  logic [AW-1:0]  prev_addr;
  logic [DW-1:0]  prev_di, wd, rd;
  logic [WEW-1:0] be;
  int ad;

  always @(negedge clk) begin
    if (chk_on) begin
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        ptr = 0; cyc = 0; q.delete();
        prev_en = 0; prev_we = '0; prev_addr = '0; prev_di = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      end
      gi = -1;
      for (int off = 0; off < N; off++)
        if (gi < 0 && req_valid[(ptr + off) % N]) gi = (ptr + off) % N;
      exp_r = '0;
      if (gi >= 0) exp_r[gi] = 1'b1;
      chk("m_ready", req_ready, exp_r);
      chk("m_init_done", init_done, 1);
      chk("m_regce", bram_regce, (RL == 2) ? 1 : 0);
      chk("m_bram_en", bram_en, prev_en);
      chk("m_bram_we", bram_we, prev_we);
      if (prev_en) chk("m_bram_addr", bram_addr, prev_addr);
      if (prev_we != 0) chk("m_bram_di", bram_di, prev_di);
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("m_rsp_valid", rsp_valid, q[0].tag);
        chk("m_rsp_rdata", rsp_rdata, q[0].data);
        void'(q.pop_front());
      end else begin
        chk("m_rsp_idle", rsp_valid, 0);
      end
      if (gi >= 0) begin
        ptr = (gi + 1) % N;
        ad = int'(req_addr[gi*AW +: AW]);
        prev_en = 1; prev_addr = AW'(ad);
        if (req_write[gi]) begin
          be = req_be[gi*WEW +: WEW];
          wd = req_wdata[gi*DW +: DW];
          prev_we = be; prev_di = wd;
          for (int k = 0; k < WEW; k++)
            if (be[k]) shadow[ad][k*LW +: LW] = wd[k*LW +: LW];
        end else begin
          prev_we = '0;
          rd = shadow[ad];
          q.push_back('{due: cyc + 1 + RL, tag: exp_r, data: rd});
        end
      end else begin
        prev_en = 0; prev_we = '0;
      end
      cyc++;
    end
  end

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      v[i] = 0; w[i] = 0; a[i] = '0; d[i] = '0; b[i] = '0;
    end
  endtask

  task automatic set_one(input int i, input logic wr, input logic [AW-1:0] ad_i,
                         input logic [DW-1:0] da, input logic [WEW-1:0] be_i);
    idle();
    v[i] = 1; w[i] = wr; a[i] = ad_i; d[i] = da; b[i] = be_i;
  endtask

  // Called with rst high: releases it and pins the zero-fill sequence with literals
  task automatic do_clear();
    for (int i = 0; i < N; i++) v[i] = 1;
    @(negedge clk) rst = 0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("clr_en", bram_en, 1);
      chk("clr_we", bram_we, 2'b11);
      chk("clr_addr", bram_addr, k);
      chk("clr_di", bram_di, 0);
      chk("clr_ready", req_ready, 0);
      chk("clr_rsp", rsp_valid, 0);
      chk("clr_init", init_done, 0);
    end
    idle();
    @(negedge clk);
    chk("clr_done_init", init_done, 1);
    chk("clr_done_ready", req_ready, 0);
    chk("clr_done_en", bram_en, 0);
    epoch++;
    chk_on = 1;
  endtask

  task automatic wait_rsp();
    @(posedge clk) #1 idle();
    @(negedge clk);
    repeat (RL) @(negedge clk);
  endtask

  logic [N-1:0] rr_exp [5];
  logic [N-1:0] hs;

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1;
    idle();
    chk("rst_outputs", {rsp_valid, init_done, bram_en, bram_we, bram_regce}, 0);
    repeat (2) @(posedge clk);
    chk("rst_ready", req_ready, 0);
    do_clear();

    // Cleared RAM reads zero; req3 leaves the pointer at 0
    @(posedge clk) #1 set_one(3, 0, 4'd7, '0, '0);
    @(negedge clk) chk("t1_ready", req_ready, 4'b1000);
    wait_rsp();
    chk("t1_rsp_valid", rsp_valid, 4'b1000);
    chk("t1_rdata", rsp_rdata, 0);

    // Round robin with everybody requesting, then a lone requester
    @(posedge clk) #1 for (int i = 0; i < N; i++) begin v[i] = 1; w[i] = 0; a[i] = AW'(i); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) chk("t3_rr", req_ready, rr_exp[k]);
    end
    @(posedge clk) #1 set_one(2, 0, 4'd2, '0, '0);
    @(negedge clk) chk("t3_lone", req_ready, 4'b0100);

    // Write then read back
    @(posedge clk) #1 set_one(0, 1, 4'd5, 18'h2A5A, 2'b11);
    @(negedge clk) chk("t2_wr_ready", req_ready, 4'b0001);
    @(posedge clk) #1 set_one(0, 0, 4'd5, '0, '0);
    @(negedge clk) chk("t2_rd_ready", req_ready, 4'b0001);
    wait_rsp();
    chk("t2_rsp_valid", rsp_valid, 4'b0001);
    chk("t2_rdata", rsp_rdata, 18'h2A5A);

    // Byte-lane write
    @(posedge clk) #1 set_one(0, 1, 4'd9, 18'h3FFFF, 2'b11);
    @(posedge clk) #1 set_one(0, 1, 4'd9, 18'h00000, 2'b01);
    @(posedge clk) #1 set_one(0, 0, 4'd9, '0, '0);
    wait_rsp();
    chk("t4_rsp_valid", rsp_valid, 4'b0001);
    chk("t4_rdata", rsp_rdata, 18'h3FE00);

    // Back-to-back write and read of one address by different requesters
    @(posedge clk) #1 set_one(1, 1, 4'd3, 18'h1234, 2'b11);
    @(negedge clk) chk("t6_wr_ready", req_ready, 4'b0010);
    @(posedge clk) #1 set_one(2, 0, 4'd3, '0, '0);
    @(negedge clk) chk("t6_rd_ready", req_ready, 4'b0100);
    wait_rsp();
    chk("t6_rsp_valid", rsp_valid, 4'b0100);
    chk("t6_rdata", rsp_rdata, 18'h1234);

    // Randomized traffic: payload held until accepted, occasional early drop
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk) hs = req_ready & req_valid;
      @(posedge clk) #1;
      for (int i = 0; i < N; i++) begin
        if (!v[i] || hs[i]) begin
          v[i] = ($urandom_range(0, 2) != 0);
          w[i] = 1'($urandom_range(0, 1));
          a[i] = AW'($urandom_range(0, DEPTH - 1));
          d[i] = DW'($urandom);
          b[i] = WEW'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          v[i] = 0;
        end
      end
    end
    @(posedge clk) #1 idle();
    repeat (RL + 3) @(negedge clk);
    chk("drain", q.size(), 0);

    // Reset with two reads outstanding
    @(posedge clk) #1 set_one(0, 0, 4'd1, '0, '0);
    @(posedge clk) #1 set_one(0, 0, 4'd2, '0, '0);
    @(posedge clk) #1 begin chk_on = 0; rst = 1; idle(); end
    @(negedge clk) chk("t5_rst_rsp", rsp_valid, 0);
    do_clear();
    @(posedge clk) #1 for (int i = 0; i < N; i++) v[i] = 1;
    @(negedge clk) chk("t5_ptr", req_ready, 4'b0001);
    @(posedge clk) #1 idle();
    repeat (RL + 3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
